// File: rtl/dual_pwm_driver.sv
// Dual-channel H-bridge PWM driver: direction decode, reversal dead-time, boundary-synchronised duty updates.
// Define PWM_SOFT_START_EN to ramp the effective duty from 0 by RAMP_STEP per period on every RUN entry.
module dual_pwm_driver #(
    parameter int unsigned PERIOD      = 1000,
    parameter int unsigned DEAD_CYCLES = 50_000,
    parameter int unsigned DUTY0       = 600,
    parameter int unsigned DUTY1       = 700,
    parameter int unsigned DUTY2       = 800,
    parameter int unsigned DUTY3       = 1000,
    parameter int unsigned RAMP_STEP   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       FWD_A,
    input  logic       BWD_A,
    input  logic       FWD_B,
    input  logic       BWD_B,
    input  logic [1:0] Duty_SelA,
    input  logic [1:0] Duty_SelB,
    output logic       IN1_A,
    output logic       IN2_A,
    output logic       IN1_B,
    output logic       IN2_B,
    output logic       PWM_A,
    output logic       PWM_B,
    output logic       Busy_A,
    output logic       Busy_B
);
    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned DW = $clog2(PERIOD + 1);
    localparam int unsigned KW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [1:0] STOP  = 2'd0;
    localparam logic [1:0] RUN_F = 2'd1;
    localparam logic [1:0] RUN_B = 2'd2;
    localparam logic [1:0] DEAD  = 2'd3;

    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic            boundary;
    logic [1:0]      fwd;
    logic [1:0]      bwd;
    logic [1:0][1:0] sel;

    assign fwd      = {FWD_B, FWD_A};
    assign bwd      = {BWD_B, BWD_A};
    assign sel      = {Duty_SelB, Duty_SelA};
    assign boundary = (cnt == CW'(PERIOD - 1));
    assign cnt_n    = boundary ? '0 : cnt + CW'(1);

`ifndef PWM_SOFT_START_EN
    logic unused_ramp;
    assign unused_ramp = ^RAMP_STEP;
`endif

    // Shared free-running period counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_n;
    end

    function automatic logic [DW-1:0] duty_of(input logic [1:0] s);
        case (s)
            2'b00:   return DW'(DUTY0);
            2'b01:   return DW'(DUTY1);
            2'b10:   return DW'(DUTY2);
            default: return DW'(DUTY3);
        endcase
    endfunction

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [1:0]    state;
        logic [1:0]    state_n;
        logic [KW-1:0] dcnt;
        logic [KW-1:0] dcnt_n;
        logic [DW-1:0] duty;
        logic [DW-1:0] duty_n;
        logic [DW-1:0] eff_n;
        logic          cmd_f;
        logic          cmd_b;
        logic          run_n;
        logic          pwm_n;
        logic          in1;
        logic          in2;
        logic          pwm;
        logic          busy;

        assign cmd_f = fwd[c] & ~bwd[c];
        assign cmd_b = bwd[c] & ~fwd[c];

`ifdef PWM_SOFT_START_EN
        logic [DW-1:0] eff;
        logic [DW:0]   ramp_sum;
        assign ramp_sum = {1'b0, eff} + (DW + 1)'(RAMP_STEP);
`endif

        // Next state, duty latch and registered-output values
        always_comb begin
            state_n = state;
            dcnt_n  = dcnt;
            duty_n  = duty;
            eff_n   = '0;
            run_n   = 1'b0;
            pwm_n   = 1'b0;
            case (state)
                STOP: begin
                    if (cmd_f)      state_n = RUN_F;
                    else if (cmd_b) state_n = RUN_B;
                end
                RUN_F: begin
                    if (cmd_b) begin
                        state_n = DEAD;
                        dcnt_n  = KW'(DEAD_CYCLES - 1);
                    end else if (!cmd_f) begin
                        state_n = STOP;
                    end
                end
                RUN_B: begin
                    if (cmd_f) begin
                        state_n = DEAD;
                        dcnt_n  = KW'(DEAD_CYCLES - 1);
                    end else if (!cmd_b) begin
                        state_n = STOP;
                    end
                end
                default: begin
                    // Exit follows whatever the command is once the dead-time has elapsed
                    if (dcnt == '0) state_n = cmd_f ? RUN_F : (cmd_b ? RUN_B : STOP);
                    else            dcnt_n  = dcnt - KW'(1);
                end
            endcase

            if (state == STOP || state == DEAD || boundary) duty_n = duty_of(sel[c]);
            run_n = (state_n == RUN_F) || (state_n == RUN_B);

`ifdef PWM_SOFT_START_EN
            if (!run_n || (state != RUN_F && state != RUN_B)) eff_n = '0;
            else if (boundary && (ramp_sum >= {1'b0, duty_n}))  eff_n = duty_n;
            else if (boundary)                                  eff_n = ramp_sum[DW-1:0];
            else                                                eff_n = eff;
`else
            eff_n = duty_n;
`endif
            pwm_n = run_n && (DW'(cnt_n) < eff_n);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= STOP;
                dcnt  <= '0;
                duty  <= DW'(DUTY0);
                in1   <= 1'b0;
                in2   <= 1'b0;
                pwm   <= 1'b0;
                busy  <= 1'b0;
            end else begin
                state <= state_n;
                dcnt  <= dcnt_n;
                duty  <= duty_n;
                in1   <= (state_n == RUN_F);
                in2   <= (state_n == RUN_B);
                pwm   <= pwm_n;
                busy  <= (state_n == DEAD);
            end
        end

`ifdef PWM_SOFT_START_EN
        always_ff @(posedge clk or posedge rst) begin
            if (rst) eff <= '0;
            else     eff <= eff_n;
        end
`endif
    end

    assign IN1_A  = g_ch[0].in1;
    assign IN2_A  = g_ch[0].in2;
    assign PWM_A  = g_ch[0].pwm;
    assign Busy_A = g_ch[0].busy;
    assign IN1_B  = g_ch[1].in1;
    assign IN2_B  = g_ch[1].in2;
    assign PWM_B  = g_ch[1].pwm;
    assign Busy_B = g_ch[1].busy;
endmodule

// File: doc/dual_pwm_driver.md
# dual_pwm_driver

Receiving end of the direction-control bus: consumes the per-wheel direction bits (FWD_A/BWD_A, FWD_B/BWD_B) and 2-bit duty selects produced by the drive-train state machines and turns them into H-bridge input pins plus PWM enables for motors A and B. It sits between direction control and the motor driver pads. It guarantees glitch-free duty updates and a mandatory dead-time on every direction reversal.

## Interface
- PERIOD, 1000: PWM period in clk cycles (100 kHz at 100 MHz); counter width $clog2(PERIOD).
- DEAD_CYCLES, 50_000: dead-time in clk cycles (0.5 ms) inserted on reversal.
- DUTY0, 600: high-time in cycles for Duty_Sel=2'b00.
- DUTY1, 700: high-time for 2'b01.
- DUTY2, 800: high-time for 2'b10.
- DUTY3, 1000: high-time for 2'b11 (must be ≤ PERIOD; equal to PERIOD means constantly high).
- RAMP_STEP, 50: duty increment per period (used only with the macro below).
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- FWD_A, BWD_A, FWD_B, BWD_B  input  1 each  direction commands per wheel.
- Duty_SelA, Duty_SelB  input  2 each  duty selects per wheel.
- IN1_A, IN2_A, IN1_B, IN2_B  output  1 each  H-bridge direction pins (IN1=1,IN2=0 forward; 0,1 backward; 0,0 coast).
- PWM_A, PWM_B  output  1 each  H-bridge enable PWM.
- Busy_A, Busy_B  output  1 each  high while the channel is in DEAD.

## Operation
- Shared free-running period counter CNT: 0..PERIOD-1, wraps to 0. Boundary = cycle where CNT==PERIOD-1.
- Per-channel command decode: FWD&~BWD = F; BWD&~FWD = B; both 0 or both 1 = S (illegal 11 treated as stop).
- Per-channel FSM, states STOP, RUN_F, RUN_B, DEAD:
  - STOP: IN=00, PWM=0. Cmd F -> RUN_F, B -> RUN_B, S -> stay.
  - RUN_F: IN=10. Cmd B -> DEAD (pending=B); S -> STOP; F -> stay.
  - RUN_B: IN=01. Cmd F -> DEAD (pending=F); S -> STOP; B -> stay.
  - DEAD: IN=00, PWM=0, Busy=1; dead counter loads DEAD_CYCLES-1 on entry, decrements each cycle. At 0: go to pending direction if cmd still equals pending, else to STOP if cmd is S, else to the other RUN state via a fresh DEAD? No — if cmd reverted to the original direction, go directly to that RUN state (reversal never completed). Cmd changes during DEAD update pending but do not restart the counter.
- Duty latch per channel: selected DUTYn. While in STOP or DEAD, latch follows Duty_Sel every cycle. While in RUN, latch updates only at the boundary, so a mid-period select change takes effect at the next CNT==0.
- PWM = 1 in RUN states when CNT < duty latch; otherwise 0.
- Channels are fully independent except for the shared CNT.

## Timing
- All outputs registered; reset values: IN1_A=IN2_A=IN1_B=IN2_B=0, PWM_A=PWM_B=0, Busy_A=Busy_B=0, FSMs=STOP, CNT=0, duty latches=DUTY0.
- Command-to-pin latency: one clk from input change to IN/PWM change (STOP->RUN, RUN->STOP, RUN->DEAD).
- Reversal: IN pins are 00 for exactly DEAD_CYCLES cycles, then new direction appears next cycle.
- IN1 and IN2 of a channel are never both 1, in any state, including reset exit.
- rst asserted mid-DEAD or mid-period: all outputs to reset values asynchronously; no pending state survives.

## Configuration
- PWM_SOFT_START_EN defined: on STOP->RUN or DEAD->RUN the effective duty starts at 0 and increases by RAMP_STEP at each boundary, saturating at the duty latch; a lower target is applied at the next boundary without ramping.
- Not defined: effective duty equals the duty latch immediately on RUN entry; RAMP_STEP ignored.

## Test plan
- Params PERIOD=10, DEAD_CYCLES=20, DUTY0..3=4,6,8,10: reset release, FWD_A=1, Duty_SelA=00 -> IN1_A=1 next cycle, PWM_A high 4 of every 10 cycles.
- Running A forward, switch to BWD_A=1,FWD_A=0 -> IN1_A=IN2_A=0, PWM_A=0, Busy_A=1 for 20 cycles, then IN2_A=1 with PWM.
- Duty_SelA 00->11 at CNT=5 while running -> current period keeps 4-cycle high, next period PWM_A high all 10 cycles.
- FWD_B=BWD_B=1 -> channel B IN pins 00, PWM_B=0; channel A unaffected.
- rst pulse during DEAD at cycle 7 -> all outputs 0 immediately, Busy_A=0, FSM STOP after release.
- With PWM_SOFT_START_EN, RAMP_STEP=2, Duty_SelA=10 from STOP -> per-period high times 0,2,4,6,8,8.
